tmr32_cmp_sequencer: RTL and testbench
======================================

Name: tmr32_cmp_sequencer

Overview:
Duty-cycle sequencer that drives the cmpx/cmpy compare inputs of the 32-bit timer/PWM core. Software preloads a FIFO of (cmpx, cmpy) pairs. The block applies one pair per N timer periods, advancing on each period boundary (rising edge of the timer's timeout_flag). It supports drain-once and loop (recirculate) modes, so PWM waveforms can be sequenced without CPU intervention.

Parameters:
AW, 3, FIFO address width; depth DEPTH = 2**AW entries
DW, 32, compare value width; must match timer width

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
en  in  1  sequencer enable; level-sensitive
loop  in  1  1: recirculate popped entries to the FIFO tail; 0: drain once
rpt  in  8  extra periods per entry; each entry is held rpt+1 periods
flush  in  1  synchronous FIFO clear, one-cycle pulse
wr  in  1  push request, one-cycle pulse per entry
wdata_x  in  DW  cmpx value to push
wdata_y  in  DW  cmpy value to push
timeout_flag  in  1  from the timer; may stay high for several clocks (prescaler)
cmpx  out  DW  compare X to the timer
cmpy  out  DW  compare Y to the timer
busy  out  1  state is RUN
done  out  1  one-cycle pulse when a drain-once sequence ends
wr_err  out  1  one-cycle pulse when a push is dropped
empty  out  1  FIFO empty
full  out  1  FIFO full
level  out  AW+1  FIFO occupancy, 0..DEPTH

Behaviour:
- Reset is asynchronous, active-low. Reset values: cmpx=0, cmpy=0, busy=0, done=0, wr_err=0, empty=1, full=0, level=0, rep_cnt=0, state IDLE, boundary edge register=0.
- Boundary detection: bnd = timeout_flag & ~tf_q, where tf_q is timeout_flag registered every clock. There is exactly one bnd per period regardless of prescaler.
- FIFO: DW*2 data bits per entry, pointer-based, level counter AW+1 bits wide. Read data is combinational from the read pointer.
- The "pop" action does all of the following on one clock edge:
  - cmpx/cmpy <= head entry.
  - rep_cnt <= rpt.
  - rd_ptr advances.
  - If loop=1, the same entry is written at the tail (recirculate), so level is unchanged.
- States:
  - IDLE:
    - busy=0; cmpx/cmpy hold their last values.
    - If en=1 and empty=0: pop and go to RUN on the same edge. The first entry is visible on cmpx/cmpy one clock after en is seen high with a non-empty FIFO.
    - If en=1 and empty=1: stay in IDLE and wait.
  - RUN:
    - busy=1.
    - On bnd with rep_cnt!=0: rep_cnt <= rep_cnt-1.
    - On bnd with rep_cnt==0 and empty=0: pop (new values apply from the next clock).
    - On bnd with rep_cnt==0 and empty=1 (only possible with loop=0): done pulses for 1 cycle, go to IDLE, cmpx/cmpy keep the last entry.
  - en=0 in any state: go to IDLE on the next edge. FIFO, cmpx/cmpy and rep_cnt are preserved; no done pulse. Re-enabling performs a fresh pop.
- Changing rpt takes effect at the next pop only. Changing loop takes effect at the next pop.
- Write acceptance:
  - wr is accepted iff (level - pop_nonloop) < DEPTH and no recirculate write occurs in that cycle.
  - Recirculation has priority over wr; a wr in the same cycle as a loop-mode pop is dropped with wr_err=1.
  - wr while full with no pop: dropped, wr_err=1.
  - wr and drain pop in the same cycle when full: accepted; level stays DEPTH.
- flush: pointers and level go to 0, empty=1. Flush has priority over wr and pop in the same cycle. If in RUN, the current entry continues until its rep_cnt expires; then drain ends normally (done) or, in loop mode, the block goes to IDLE with no done.
- wr_err and done are registered one-cycle pulses.
- full = (level==DEPTH); empty = (level==0). Both are derived from the registered level.
- Pointers wrap modulo DEPTH.

Test Plan:
- Drain-once sequence:
  - Stimulus: push (100,200), (300,400), (500,600); loop=0, rpt=0, en=1; pulse timeout_flag every 20 clocks, high for 3 clocks each time.
  - Response: cmpx=100 one clock after en; then 300 and 500 one clock after successive timeout_flag rising edges; done pulses on the 3rd edge; state returns to IDLE; cmpx stays 500; level=0.
- Repeat count:
  - Stimulus: rpt=2, push (10,20), (30,40).
  - Response: cmpx changes 10 to 30 only on the 3rd boundary after start; done pulses on the 6th boundary.
- Loop mode:
  - Stimulus: loop=1, push 2 entries (A, B).
  - Response: cmpx cycles A, B, A, B over 8 boundaries; level stays 2; done is never asserted.
- Full/overflow:
  - Stimulus: push DEPTH=8 entries, then one more while idle.
  - Response: full=1, level=8, wr_err pulses once, 9th entry is discarded.
  - Stimulus: a wr in the same cycle as a drain pop while full.
  - Response: wr accepted, level stays 8.
- Loop collision:
  - Stimulus: loop=1, assert wr on the same cycle as a boundary pop.
  - Response: wr_err=1, level unchanged.
- Flush / enable / reset:
  - Stimulus: flush mid-RUN with loop=0, rpt=0.
  - Response: level=0 immediately; done pulses at the next boundary.
  - Stimulus: en dropped mid-RUN.
  - Response: busy=0 next clock, cmpx held.
  - Stimulus: rst_n asserted asynchronously mid-RUN.
  - Response: all outputs go to their reset values without waiting for clk.

Source files
------------

// File: rtl/tmr32_cmp_sequencer.sv
// Compare-value sequencer for the 32-bit timer/PWM core: applies one (cmpx, cmpy)
// pair from a small FIFO per rpt+1 timer periods, in drain-once or recirculating mode.
module tmr32_cmp_sequencer #(
    parameter int AW = 3,
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          en,
    input  logic          loop,
    input  logic [7:0]    rpt,
    input  logic          flush,
    input  logic          wr,
    input  logic [DW-1:0] wdata_x,
    input  logic [DW-1:0] wdata_y,
    input  logic          timeout_flag,
    output logic [DW-1:0] cmpx,
    output logic [DW-1:0] cmpy,
    output logic          busy,
    output logic          done,
    output logic          wr_err,
    output logic          empty,
    output logic          full,
    output logic [AW:0]   level
);

    localparam int DEPTH = 2 ** AW;
    localparam logic [AW:0] DEPTH_L = (AW + 1)'(DEPTH);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic            tf_q;
    logic            bnd;
    logic [7:0]      rep_cnt;
    logic            loop_q;
    logic [2*DW-1:0] mem [DEPTH];
    logic [2*DW-1:0] head;
    logic [AW-1:0]   rd_ptr;
    logic [AW-1:0]   wr_ptr;
    logic [AW:0]     level_q;

    logic pop;
    logic rep_dec;
    logic seq_end;
    logic recirc;
    logic pop_nl;
    logic wr_ok;
    logic done_nxt;

    // One boundary per timer period, however long the prescaled flag stays high.
    assign bnd   = timeout_flag & ~tf_q;
    assign head  = mem[rd_ptr];
    assign empty = (level_q == '0);
    assign full  = (level_q == DEPTH_L);
    assign level = level_q;
    assign busy  = (state == RUN);

    always_comb begin
        state_nxt = state;
        pop       = 1'b0;
        rep_dec   = 1'b0;
        seq_end   = 1'b0;
        if (!en) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (!empty && !flush) begin
                        pop       = 1'b1;
                        state_nxt = RUN;
                    end
                end
                RUN: begin
                    if (bnd) begin
                        if (rep_cnt != 8'd0) begin
                            rep_dec = 1'b1;
                        end else if (!empty && !flush) begin
                            pop = 1'b1;
                        end else begin
                            seq_end   = 1'b1;
                            state_nxt = IDLE;
                        end
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    // Recirculation claims the write port, so a push in the same cycle is dropped.
    assign recirc   = pop & loop;
    assign pop_nl   = pop & ~loop;
    assign wr_ok    = wr & ~flush & ~recirc &
                      ((level_q - {{AW{1'b0}}, pop_nl}) < DEPTH_L);
    // A loop-mode sequence that runs dry only because of a flush ends silently.
    assign done_nxt = seq_end & ~loop_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            tf_q    <= 1'b0;
            rep_cnt <= 8'd0;
            loop_q  <= 1'b0;
            cmpx    <= '0;
            cmpy    <= '0;
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            level_q <= '0;
            done    <= 1'b0;
            wr_err  <= 1'b0;
        end else begin
            state  <= state_nxt;
            tf_q   <= timeout_flag;
            done   <= done_nxt;
            wr_err <= wr & ~wr_ok;
            if (rep_dec) begin
                rep_cnt <= rep_cnt - 8'd1;
            end
            if (pop) begin
                {cmpx, cmpy} <= head;
                rep_cnt      <= rpt;
                loop_q       <= loop;
            end
            if (flush) begin
                rd_ptr  <= '0;
                wr_ptr  <= '0;
                level_q <= '0;
            end else begin
                if (pop) begin
                    rd_ptr <= rd_ptr + 1'b1;
                end
                if (recirc || wr_ok) begin
                    wr_ptr <= wr_ptr + 1'b1;
                end
                level_q <= level_q + (AW + 1)'(wr_ok) - (AW + 1)'(pop_nl);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (recirc || wr_ok) begin
            mem[wr_ptr] <= recirc ? head : {wdata_x, wdata_y};
        end
    end

endmodule

// File: tb/tb_tmr32_cmp_sequencer.sv
// Scoreboard bench for tmr32_cmp_sequencer: expected compare updates and done pulses,
// tagged with the timer boundary at which they must appear.
module tb_tmr32_cmp_sequencer;

    localparam int AW    = 3;
    localparam int DW    = 32;
    localparam int DEPTH = 8;

    logic          clk          = 1'b0;
    logic          rst_n        = 1'b1;
    logic          en           = 1'b0;
    logic          loop         = 1'b0;
    logic [7:0]    rpt          = 8'd0;
    logic          flush        = 1'b0;
    logic          wr           = 1'b0;
    logic [DW-1:0] wdata_x      = '0;
    logic [DW-1:0] wdata_y      = '0;
    logic          timeout_flag = 1'b0;
    logic [DW-1:0] cmpx;
    logic [DW-1:0] cmpy;
    logic          busy;
    logic          done;
    logic          wr_err;
    logic          empty;
    logic          full;
    logic [AW:0]   level;

    tmr32_cmp_sequencer #(.AW(AW), .DW(DW)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .loop(loop), .rpt(rpt), .flush(flush),
        .wr(wr), .wdata_x(wdata_x), .wdata_y(wdata_y), .timeout_flag(timeout_flag),
        .cmpx(cmpx), .cmpy(cmpy), .busy(busy), .done(done), .wr_err(wr_err),
        .empty(empty), .full(full), .level(level)
    );

    always #5 clk = ~clk;

    int          n_tests = 0;
    int          n_fail  = 0;
    int          bnd_num = 0;
    // {kind(1=done), boundary index[15:0], x[31:0], y[31:0]}
    logic [80:0] exp_q[$];
    logic [63:0] model_q[$];
    logic [31:0] gen_last_x = '0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    task automatic exp_push(input logic kind, input logic [63:0] xy, input int b);
        exp_q.push_back({kind, 16'(b), xy});
    endtask

    // Reference schedule: entry k lands at boundary b0 + k*(rpt+1); a drain ends one slot later.
    task automatic expect_run(input int nb, input int r, input bit lp);
        int n;
        int b0;
        int t;
        n  = model_q.size();
        b0 = bnd_num;
        for (int k = 0; k * (r + 1) <= nb; k++) begin
            t = b0 + k * (r + 1);
            if (lp) begin
                exp_push(1'b0, model_q[k % n], t);
            end else if (k < n) begin
                exp_push(1'b0, model_q[k], t);
            end else begin
                exp_push(1'b1, 64'h0, t);
                break;
            end
        end
    endtask

    task automatic gen_entry(output logic [63:0] xy);
        logic [31:0] x;
        x = $urandom;
        if (x == gen_last_x) x = x + 32'd1;
        gen_last_x = x;
        xy = {x, 32'($urandom)};
    endtask

    task automatic push_entry(input logic [63:0] xy);
        wr      = 1'b1;
        wdata_x = xy[63:32];
        wdata_y = xy[31:0];
        if (model_q.size() < DEPTH) model_q.push_back(xy);
        @(negedge clk);
        wr = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic boundary_tail();
        repeat (2) @(negedge clk);
        timeout_flag = 1'b0;
        repeat (17) @(negedge clk);
    endtask

    task automatic boundary();
        timeout_flag = 1'b1;
        bnd_num++;
        @(negedge clk);
        boundary_tail();
    endtask

    task automatic do_flush();
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        model_q.delete();
    endtask

    task automatic check_drained(input string name);
        check(name, 64'(exp_q.size()), 64'd0);
    endtask

    // Monitor: every visible compare change or done pulse must match the queue head.
    logic [DW-1:0] prev_x = '0;
    logic [DW-1:0] prev_y = '0;
    always @(negedge clk) begin
        logic [80:0] ev;
        if (!rst_n) begin
            prev_x = '0;
            prev_y = '0;
        end else begin
            if (cmpx !== prev_x || cmpy !== prev_y) begin
                if (exp_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_update: got %0h/%0h, expected no change", cmpx, cmpy);
                end else begin
                    ev = exp_q.pop_front();
                    check("update_kind", 64'(1'b0), 64'(ev[80]));
                    check("update_x", 64'(cmpx), 64'(ev[63:32]));
                    check("update_y", 64'(cmpy), 64'(ev[31:0]));
                    check("update_boundary", 64'(bnd_num[15:0]), 64'(ev[79:64]));
                end
                prev_x = cmpx;
                prev_y = cmpy;
            end
            if (done === 1'b1) begin
                if (exp_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_done: got done=1, expected 0");
                end else begin
                    ev = exp_q.pop_front();
                    check("done_kind", 64'(1'b1), 64'(ev[80]));
                    check("done_boundary", 64'(bnd_num[15:0]), 64'(ev[79:64]));
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] e0;
        logic [63:0] e1;
        logic [63:0] e2;
        logic [63:0] xy;
        int n;
        int r;
        int nb;
        int b;

        // Reset values
        #1 rst_n = 1'b0;
        idle(2);
        check("rst_cmpx", 64'(cmpx), 64'd0);
        check("rst_cmpy", 64'(cmpy), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_wr_err", 64'(wr_err), 64'd0);
        check("rst_empty", 64'(empty), 64'd1);
        check("rst_full", 64'(full), 64'd0);
        check("rst_level", 64'(level), 64'd0);
        rst_n = 1'b1;
        idle(2);

        // Drain-once with the fixed values
        push_entry({32'd100, 32'd200});
        push_entry({32'd300, 32'd400});
        push_entry({32'd500, 32'd600});
        check("s1_level", 64'(level), 64'd3);
        expect_run(3, 0, 1'b0);
        en = 1'b1;
        @(negedge clk);
        check("s1_busy", 64'(busy), 64'd1);
        check("s1_first_x", 64'(cmpx), 64'd100);
        idle(2);
        repeat (3) boundary();
        check("s1_busy_end", 64'(busy), 64'd0);
        check("s1_level_end", 64'(level), 64'd0);
        check("s1_hold_x", 64'(cmpx), 64'd500);
        check("s1_empty", 64'(empty), 64'd1);
        en = 1'b0;
        @(negedge clk);
        model_q.delete();
        check_drained("s1_drained");

        // Random drain-once runs with repeat counts (first one is rpt=2, two entries)
        for (int it = 0; it < 4; it++) begin
            n = (it == 0) ? 2 : $urandom_range(1, 4);
            r = (it == 0) ? 2 : $urandom_range(0, 3);
            for (int i = 0; i < n; i++) begin
                gen_entry(xy);
                push_entry(xy);
            end
            rpt = 8'(r);
            expect_run(n * (r + 1), r, 1'b0);
            en = 1'b1;
            idle(3);
            repeat (n * (r + 1)) boundary();
            check("s2_level", 64'(level), 64'd0);
            check("s2_busy", 64'(busy), 64'd0);
            en = 1'b0;
            @(negedge clk);
            model_q.delete();
            check_drained("s2_drained");
        end

        // Random loop-mode runs
        for (int it = 0; it < 3; it++) begin
            n  = (it == 0) ? 2 : $urandom_range(2, 4);
            r  = (it == 0) ? 0 : $urandom_range(0, 2);
            nb = (it == 0) ? 8 : $urandom_range(4, 8);
            loop = 1'b1;
            rpt  = 8'(r);
            for (int i = 0; i < n; i++) begin
                gen_entry(xy);
                push_entry(xy);
            end
            expect_run(nb, r, 1'b1);
            en = 1'b1;
            idle(3);
            repeat (nb) boundary();
            check("s3_level", 64'(level), 64'(n));
            en = 1'b0;
            @(negedge clk);
            check("s3_busy", 64'(busy), 64'd0);
            do_flush();
            check("s3_flush_level", 64'(level), 64'd0);
            loop = 1'b0;
            check_drained("s3_drained");
        end

        // Full / overflow, then push alongside a drain pop while full
        rpt = 8'd0;
        for (int i = 0; i < DEPTH; i++) begin
            gen_entry(xy);
            push_entry(xy);
        end
        check("s4_level_full", 64'(level), 64'd8);
        check("s4_full", 64'(full), 64'd1);
        push_entry({32'($urandom), 32'($urandom)});
        check("s4_wr_err", 64'(wr_err), 64'd1);
        check("s4_level_keep", 64'(level), 64'd8);
        @(negedge clk);
        check("s4_wr_err_pulse", 64'(wr_err), 64'd0);
        gen_entry(xy);
        model_q.push_back(xy);
        expect_run(9, 0, 1'b0);
        en      = 1'b1;
        wr      = 1'b1;
        wdata_x = xy[63:32];
        wdata_y = xy[31:0];
        @(negedge clk);
        wr = 1'b0;
        check("s4_pop_wr_level", 64'(level), 64'd8);
        check("s4_pop_wr_err", 64'(wr_err), 64'd0);
        idle(2);
        repeat (9) boundary();
        check("s4_level_end", 64'(level), 64'd0);
        en = 1'b0;
        @(negedge clk);
        model_q.delete();
        check_drained("s4_drained");

        // Loop collision: push on the same cycle as a recirculating pop
        loop = 1'b1;
        gen_entry(xy);
        push_entry(xy);
        gen_entry(xy);
        push_entry(xy);
        expect_run(4, 0, 1'b1);
        en = 1'b1;
        idle(3);
        boundary();
        timeout_flag = 1'b1;
        bnd_num++;
        wr      = 1'b1;
        wdata_x = $urandom;
        wdata_y = $urandom;
        @(negedge clk);
        wr = 1'b0;
        check("s5_wr_err", 64'(wr_err), 64'd1);
        check("s5_level", 64'(level), 64'd2);
        boundary_tail();
        boundary();
        boundary();
        check("s5_level_end", 64'(level), 64'd2);
        en = 1'b0;
        @(negedge clk);
        do_flush();
        loop = 1'b0;
        check_drained("s5_drained");

        // Flush mid-run: current entry finishes, then done
        gen_entry(e0);
        push_entry(e0);
        gen_entry(e1);
        push_entry(e1);
        gen_entry(e2);
        push_entry(e2);
        b = bnd_num;
        exp_push(1'b0, e0, b);
        exp_push(1'b0, e1, b + 1);
        exp_push(1'b1, 64'h0, b + 2);
        en = 1'b1;
        idle(3);
        boundary();
        do_flush();
        check("s6_level", 64'(level), 64'd0);
        check("s6_empty", 64'(empty), 64'd1);
        check("s6_busy", 64'(busy), 64'd1);
        boundary();
        check("s6_busy_end", 64'(busy), 64'd0);
        en = 1'b0;
        @(negedge clk);
        check_drained("s6_drained");

        // Enable dropped mid-run, then re-enabled for a fresh pop
        gen_entry(e0);
        push_entry(e0);
        gen_entry(e1);
        push_entry(e1);
        exp_push(1'b0, e0, bnd_num);
        en = 1'b1;
        idle(3);
        en = 1'b0;
        @(negedge clk);
        check("s7_busy", 64'(busy), 64'd0);
        check("s7_hold_x", 64'(cmpx), 64'(e0[63:32]));
        check("s7_level", 64'(level), 64'd1);
        idle(2);
        exp_push(1'b0, e1, bnd_num);
        exp_push(1'b1, 64'h0, bnd_num + 1);
        en = 1'b1;
        @(negedge clk);
        check("s7_busy_again", 64'(busy), 64'd1);
        idle(2);
        boundary();
        check("s7_busy_end", 64'(busy), 64'd0);
        check("s7_level_end", 64'(level), 64'd0);
        en = 1'b0;
        @(negedge clk);
        model_q.delete();
        check_drained("s7_drained");

        // Asynchronous reset mid-run
        gen_entry(e0);
        push_entry(e0);
        gen_entry(e1);
        push_entry(e1);
        exp_push(1'b0, e0, bnd_num);
        en = 1'b1;
        idle(3);
        check_drained("s8_first_pop");
        #2 rst_n = 1'b0;
        #1;
        check("s8_cmpx", 64'(cmpx), 64'd0);
        check("s8_cmpy", 64'(cmpy), 64'd0);
        check("s8_busy", 64'(busy), 64'd0);
        check("s8_level", 64'(level), 64'd0);
        check("s8_empty", 64'(empty), 64'd1);
        check("s8_full", 64'(full), 64'd0);
        check("s8_done", 64'(done), 64'd0);
        check("s8_wr_err", 64'(wr_err), 64'd0);
        en = 1'b0;
        idle(2);
        rst_n = 1'b1;
        model_q.delete();
        idle(2);
        check("s8_busy_after", 64'(busy), 64'd0);
        check("s8_level_after", 64'(level), 64'd0);
        check_drained("final_drained");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
